// File: rtl/axi_rd_burst_master.sv
// -----------------------------------------------------------------------------
// axi_rd_burst_master
//
// This block reads a linear region of memory over AXI4 and returns it as a
// stream of narrow user words. A request gives a start address and a length in
// AXI beats. The block splits the request into INCR bursts. Each burst is no
// longer than P_MAX_BURST beats and never crosses a 4KB boundary. A burst is
// issued only when the internal buffer can hold every beat of it, so the R
// channel never has to stall because the buffer is full. Each buffered AXI word
// is returned as P_AXI_DATA_WIDTH/P_USER_DATA_WIDTH user words, lowest word
// first.
//
// Optional feature (compile-time macro RD_RESP_CHECK_EN):
//   When defined, o_rd_err becomes a sticky flag. It is set by any accepted R
//   beat whose RRESP is not OKAY or whose RID is not P_AXI_ID. It is cleared by
//   the next request handshake. When the macro is not defined, o_rd_err is
//   tied to 0.
//
// Ports:
//   i_axi_clk, i_rst                 clock, synchronous active-high reset
//   i_req_valid/o_req_ready          request handshake (ready only when idle)
//   i_req_addr, i_req_beats          start byte address, length in AXI beats
//   o_user_data/valid/last           user word stream, held until i_user_ready
//   i_user_ready                     user-side backpressure
//   o_busy                           request in progress
//   o_rd_err                         sticky response error (see macro above)
//   o_axi_ar*, i_axi_arready         AXI read address channel
//   i_axi_r*, o_axi_rready           AXI read data channel
// -----------------------------------------------------------------------------
module axi_rd_burst_master #(
   parameter int P_USER_DATA_WIDTH = 16,
   parameter int P_AXI_DATA_WIDTH  = 128,
   parameter int P_AXI_ADDR_WIDTH  = 32,
   parameter int P_MAX_BURST       = 16,
   parameter int P_FIFO_DEPTH      = 64,
   parameter int P_AXI_ID          = 0
) (
   input  logic                          i_axi_clk,
   input  logic                          i_rst,
   input  logic                          i_req_valid,
   output logic                          o_req_ready,
   input  logic [P_AXI_ADDR_WIDTH-1:0]   i_req_addr,
   input  logic [15:0]                   i_req_beats,
   output logic [P_USER_DATA_WIDTH-1:0]  o_user_data,
   output logic                          o_user_valid,
   input  logic                          i_user_ready,
   output logic                          o_user_last,
   output logic                          o_busy,
   output logic                          o_rd_err,
   output logic                          o_axi_arvalid,
   input  logic                          i_axi_arready,
   output logic [P_AXI_ADDR_WIDTH-1:0]   o_axi_araddr,
   output logic [7:0]                    o_axi_arlen,
   output logic [2:0]                    o_axi_arsize,
   output logic [1:0]                    o_axi_arburst,
   output logic [3:0]                    o_axi_arid,
   output logic                          o_axi_arlock,
   output logic [3:0]                    o_axi_arcache,
   output logic [2:0]                    o_axi_arprot,
   output logic [3:0]                    o_axi_arqos,
   input  logic [3:0]                    i_axi_rid,
   input  logic [P_AXI_DATA_WIDTH-1:0]   i_axi_rdata,
   input  logic [1:0]                    i_axi_rresp,
   input  logic                          i_axi_rvalid,
   input  logic                          i_axi_rlast,
   output logic                          o_axi_rready
);

   localparam int RATIO = P_AXI_DATA_WIDTH / P_USER_DATA_WIDTH;
   localparam int BYTES = P_AXI_DATA_WIDTH / 8;
   localparam int SIZE  = $clog2(BYTES);
   localparam int PTR_W = $clog2(P_FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SEL_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int LEN_W = 17;

   typedef enum logic [2:0] {S_IDLE, S_CALC, S_AR, S_RD, S_DONE} state_t;

   state_t                       state_q;
   logic [P_AXI_ADDR_WIDTH-1:0]  addr_q;
   logic [15:0]                  remaining_q;
   logic [8:0]                   len_q;
   logic                         zero_q;
   logic                         dwell_q;

   logic [P_AXI_DATA_WIDTH:0]    mem [P_FIFO_DEPTH];
   logic [PTR_W-1:0]             wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]             fifo_cnt_q;
   logic [SEL_W-1:0]             sel_q;

   assign o_axi_arsize  = 3'(SIZE);
   assign o_axi_arburst = 2'b01;
   assign o_axi_arid    = 4'(P_AXI_ID);
   assign o_axi_arlock  = 1'b0;
   assign o_axi_arcache = 4'd0;
   assign o_axi_arprot  = 3'd0;
   assign o_axi_arqos   = 4'd0;

   // Burst sizing. The address is always aligned to the AXI width, so the
   // number of bytes left in the current 4KB page divides exactly into beats.
   logic [12:0]      to_4k_bytes;
   logic [LEN_W-1:0] to_4k_beats, burst_len, fifo_free;

   assign to_4k_bytes = 13'h1000 - {1'b0, addr_q[11:0]};
   assign to_4k_beats = LEN_W'(to_4k_bytes >> SIZE);
   assign fifo_free   = LEN_W'(P_FIFO_DEPTH) - LEN_W'(fifo_cnt_q);

   // NOTE: assign a default first so every path writes burst_len and no latch is inferred.
   always_comb begin
      burst_len = LEN_W'(remaining_q);
      if (burst_len > LEN_W'(P_MAX_BURST)) burst_len = LEN_W'(P_MAX_BURST);
      if (burst_len > to_4k_beats)         burst_len = to_4k_beats;
   end

   logic        r_accept, burst_end, final_burst, push, pop, load, sel_last;
   logic [15:0] remaining_next;

   assign r_accept       = o_axi_rready && i_axi_rvalid;
   assign burst_end      = r_accept && i_axi_rlast;
   assign final_burst    = (LEN_W'(remaining_q) == LEN_W'(len_q));
   assign remaining_next = remaining_q - 16'(len_q);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_axi_clk) begin
      if (i_rst) begin
         state_q       <= S_IDLE;
         o_req_ready   <= 1'b0;
         o_busy        <= 1'b0;
         o_axi_arvalid <= 1'b0;
         o_axi_araddr  <= '0;
         o_axi_arlen   <= '0;
         o_axi_rready  <= 1'b0;
         addr_q        <= '0;
         remaining_q   <= '0;
         len_q         <= '0;
         zero_q        <= 1'b0;
         dwell_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               o_req_ready <= 1'b1;
               o_busy      <= 1'b0;
               if (i_req_valid && o_req_ready) begin
                  o_req_ready <= 1'b0;
                  o_busy      <= 1'b1;
                  addr_q      <= i_req_addr;
                  remaining_q <= i_req_beats;
                  zero_q      <= (i_req_beats == 16'd0);
                  dwell_q     <= 1'b0;
                  state_q     <= (i_req_beats == 16'd0) ? S_DONE : S_CALC;
               end
            end
            S_CALC: begin
               // Reserve room for the whole burst before issuing it.
               if (fifo_free >= burst_len) begin
                  len_q         <= 9'(burst_len);
                  o_axi_araddr  <= addr_q;
                  o_axi_arlen   <= 8'(burst_len - 1'b1);
                  o_axi_arvalid <= 1'b1;
                  state_q       <= S_AR;
               end
            end
            S_AR: begin
               if (i_axi_arready) begin
                  o_axi_arvalid <= 1'b0;
                  o_axi_rready  <= 1'b1;
                  state_q       <= S_RD;
               end
            end
            S_RD: begin
               // RLAST ends the burst even if the slave's beat count differs from arlen.
               if (burst_end) begin
                  addr_q       <= addr_q + (P_AXI_ADDR_WIDTH'(len_q) << SIZE);
                  remaining_q  <= remaining_next;
                  o_axi_rready <= 1'b0;
                  state_q      <= (remaining_next != 16'd0) ? S_CALC : S_DONE;
               end
            end
            S_DONE: begin
               if (zero_q) begin
                  // A zero-beat request waits one extra cycle here before it returns to idle.
                  if (dwell_q) begin
                     zero_q      <= 1'b0;
                     o_busy      <= 1'b0;
                     o_req_ready <= 1'b1;
                     state_q     <= S_IDLE;
                  end else begin
                     dwell_q <= 1'b1;
                  end
               end else if (o_user_valid && o_user_last && i_user_ready) begin
                  o_busy      <= 1'b0;
                  o_req_ready <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Beat buffer. The full guard only matters if a slave sends more beats than it was asked for.
   assign push = r_accept && (fifo_cnt_q != CNT_W'(P_FIFO_DEPTH));

   // NOTE: the storage array has no reset; emptiness is tracked only by the pointers and the count.
   always_ff @(posedge i_axi_clk) begin
      if (push) mem[wr_ptr_q] <= {i_axi_rlast && final_burst, i_axi_rdata};
   end

   always_ff @(posedge i_axi_clk) begin
      if (i_rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
            default: fifo_cnt_q <= fifo_cnt_q;
         endcase
      end
   end

   // Width conversion. The output register reloads in the same cycle a word is
   // taken, so words stream without gaps while i_user_ready stays high.
   logic [P_AXI_DATA_WIDTH-1:0] head_data;
   logic                        head_last;

   assign {head_last, head_data} = mem[rd_ptr_q];
   assign load     = (fifo_cnt_q != '0) && (!o_user_valid || i_user_ready);
   assign sel_last = (sel_q == SEL_W'(RATIO - 1));
   assign pop      = load && sel_last;

   always_ff @(posedge i_axi_clk) begin
      if (i_rst) begin
         o_user_valid <= 1'b0;
         o_user_data  <= '0;
         o_user_last  <= 1'b0;
         sel_q        <= '0;
      end else if (load) begin
         o_user_data  <= head_data[sel_q*P_USER_DATA_WIDTH +: P_USER_DATA_WIDTH];
         o_user_last  <= head_last && sel_last;
         o_user_valid <= 1'b1;
         sel_q        <= sel_last ? '0 : sel_q + 1'b1;
      end else if (i_user_ready) begin
         o_user_valid <= 1'b0;
         o_user_last  <= 1'b0;
      end
   end

`ifdef RD_RESP_CHECK_EN
   always_ff @(posedge i_axi_clk) begin
      if (i_rst) begin
         o_rd_err <= 1'b0;
      end else if (i_req_valid && o_req_ready) begin
         o_rd_err <= 1'b0;
      end else if (r_accept && ((i_axi_rresp != 2'b00) || (i_axi_rid != 4'(P_AXI_ID)))) begin
         o_rd_err <= 1'b1;
      end
   end
`else
   logic unused_resp;
   assign unused_resp = ^{i_axi_rid, i_axi_rresp};
   assign o_rd_err    = 1'b0;
`endif

endmodule

// File: tb/tb_axi_rd_burst_master.sv
// -----------------------------------------------------------------------------
// tb_axi_rd_burst_master
//
// Directed testbench for axi_rd_burst_master with default parameters. A
// behavioural AXI slave returns beats whose 16-bit lanes hold their own
// halfword address, (byte_addr >> 1). The expected user word n of a request is
// therefore ((start >> 1) + n) mod 2^16. The expected AR address and length of
// every burst are written out by hand for each case.
// -----------------------------------------------------------------------------
module tb_axi_rd_burst_master;

   logic         i_axi_clk = 1'b0;
   logic         i_rst = 1'b1;
   logic         i_req_valid = 1'b0;
   logic         o_req_ready;
   logic [31:0]  i_req_addr = '0;
   logic [15:0]  i_req_beats = '0;
   logic [15:0]  o_user_data;
   logic         o_user_valid;
   logic         i_user_ready = 1'b1;
   logic         o_user_last;
   logic         o_busy;
   logic         o_rd_err;
   logic         o_axi_arvalid;
   logic         i_axi_arready = 1'b0;
   logic [31:0]  o_axi_araddr;
   logic [7:0]   o_axi_arlen;
   logic [2:0]   o_axi_arsize;
   logic [1:0]   o_axi_arburst;
   logic [3:0]   o_axi_arid;
   logic         o_axi_arlock;
   logic [3:0]   o_axi_arcache;
   logic [2:0]   o_axi_arprot;
   logic [3:0]   o_axi_arqos;
   logic [3:0]   i_axi_rid = '0;
   logic [127:0] i_axi_rdata = '0;
   logic [1:0]   i_axi_rresp = '0;
   logic         i_axi_rvalid = 1'b0;
   logic         i_axi_rlast = 1'b0;
   logic         o_axi_rready;

   axi_rd_burst_master dut (
      .i_axi_clk(i_axi_clk), .i_rst(i_rst),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_req_addr(i_req_addr), .i_req_beats(i_req_beats),
      .o_user_data(o_user_data), .o_user_valid(o_user_valid),
      .i_user_ready(i_user_ready), .o_user_last(o_user_last),
      .o_busy(o_busy), .o_rd_err(o_rd_err),
      .o_axi_arvalid(o_axi_arvalid), .i_axi_arready(i_axi_arready),
      .o_axi_araddr(o_axi_araddr), .o_axi_arlen(o_axi_arlen),
      .o_axi_arsize(o_axi_arsize), .o_axi_arburst(o_axi_arburst),
      .o_axi_arid(o_axi_arid), .o_axi_arlock(o_axi_arlock),
      .o_axi_arcache(o_axi_arcache), .o_axi_arprot(o_axi_arprot),
      .o_axi_arqos(o_axi_arqos),
      .i_axi_rid(i_axi_rid), .i_axi_rdata(i_axi_rdata),
      .i_axi_rresp(i_axi_rresp), .i_axi_rvalid(i_axi_rvalid),
      .i_axi_rlast(i_axi_rlast), .o_axi_rready(o_axi_rready)
   );

   always #5 i_axi_clk = ~i_axi_clk;

`ifdef RD_RESP_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   int checks = 0;
   int failures = 0;

   logic [31:0] exp_ar_addr [16];
   logic [7:0]  exp_ar_len  [16];
   int          exp_ar_n;
   int          rd_delay;
   bit          toggle_ready;
   int          err_beat;
   int          beats_acc;
   int          words_acc;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Every task starts and ends 1 time unit after a rising edge.
   task automatic step();
      @(posedge i_axi_clk);
      #1;
   endtask

   function automatic logic [127:0] beat_data(input logic [31:0] a);
      logic [127:0] d;
      for (int j = 0; j < 8; j++) d[j*16 +: 16] = 16'((a + 32'(2*j)) >> 1);
      return d;
   endfunction

   task automatic send_req(input logic [31:0] addr, input logic [15:0] beats);
      int n = 0;
      while (!o_req_ready && n < 100) begin step(); n++; end
      if (!o_req_ready) check("req_ready_timeout", 0, 1);
      i_req_valid = 1'b1;
      i_req_addr  = addr;
      i_req_beats = beats;
      step();
      i_req_valid = 1'b0;
   endtask

   task automatic slave(input int total);
      int served = 0;
      int k = 0;
      int n;
      logic [31:0] a;
      logic [7:0]  l;
      while (served < total) begin
         n = 0;
         i_axi_arready = 1'b1;
         while (!o_axi_arvalid && n < 5000) begin step(); n++; end
         if (!o_axi_arvalid) begin
            check("ar_timeout", 0, 1);
            i_axi_arready = 1'b0;
            return;
         end
         a = o_axi_araddr;
         l = o_axi_arlen;
         if (k < 16) begin
            check("araddr", a, exp_ar_addr[k]);
            check("arlen", l, exp_ar_len[k]);
         end
         // Bench occupancy can run one beat ahead of the true buffer, hence the +1.
         check("ar_room", ((64 - (beats_acc - words_acc/8) + 1) >= (int'(l) + 1)), 1);
         k++;
         step();
         i_axi_arready = 1'b0;
         for (int b = 0; b <= int'(l); b++) begin
            repeat (rd_delay) step();
            i_axi_rvalid = 1'b1;
            i_axi_rdata  = beat_data(a + 32'(b*16));
            i_axi_rlast  = (b == int'(l));
            i_axi_rresp  = (served == err_beat) ? 2'b10 : 2'b00;
            n = 0;
            while (!o_axi_rready && n < 1000) begin step(); n++; end
            if (!o_axi_rready) begin
               check("r_timeout", 0, 1);
               i_axi_rvalid = 1'b0;
               return;
            end
            beats_acc++;
            served++;
            step();
            i_axi_rvalid = 1'b0;
            i_axi_rlast  = 1'b0;
            i_axi_rresp  = 2'b00;
         end
      end
      check("ar_count", k, exp_ar_n);
   endtask

   task automatic consumer(input logic [31:0] start, input int total);
      int n = 0;
      int cyc = 0;
      while (n < total && cyc < 20000) begin
         step();
         i_user_ready = toggle_ready ? ~i_user_ready : 1'b1;
         if (o_user_valid && i_user_ready) begin
            check("user_data", o_user_data, 16'((start >> 1) + 32'(n)));
            check("user_last", o_user_last, (n == total - 1));
            n++;
            words_acc++;
         end
         cyc++;
      end
      if (n < total) check("user_timeout", n, total);
      i_user_ready = 1'b1;
   endtask

   task automatic xfer(input logic [31:0] addr, input logic [15:0] beats);
      beats_acc = 0;
      words_acc = 0;
      send_req(addr, beats);
      check("rd_err_after_req", o_rd_err, 0);
      fork
         slave(int'(beats));
         consumer(addr, int'(beats) * 8);
      join
      step();
      check("busy_after", o_busy, 0);
      check("req_ready_after", o_req_ready, 1);
   endtask

   initial begin
      int n;
      int busy_cnt;
      int ar_cnt;
      int uv_cnt;
      rd_delay     = 0;
      toggle_ready = 1'b0;
      err_beat     = -1;

      // Reset state.
      repeat (3) step();
      check("rst_req_ready", o_req_ready, 0);
      check("rst_busy", o_busy, 0);
      check("rst_arvalid", o_axi_arvalid, 0);
      check("rst_user_valid", o_user_valid, 0);
      check("rst_rd_err", o_rd_err, 0);
      check("rst_rready", o_axi_rready, 0);
      check("arsize", o_axi_arsize, 3'd4);
      check("arburst", o_axi_arburst, 2'b01);
      check("arid", o_axi_arid, 4'd0);
      check("ar_misc", {o_axi_arlock, o_axi_arcache, o_axi_arprot, o_axi_arqos}, 0);
      i_rst = 1'b0;
      step();
      check("idle_req_ready", o_req_ready, 1);

      // 4 beats in one page: a single burst of 4 and 32 user words.
      exp_ar_addr[0] = 32'h0000_1000; exp_ar_len[0] = 8'd3; exp_ar_n = 1;
      xfer(32'h0000_1000, 16'd4);

      // 20 beats starting 64 bytes below a 4KB boundary.
      exp_ar_addr[0] = 32'h0000_0FC0; exp_ar_len[0] = 8'd3;
      exp_ar_addr[1] = 32'h0000_1000; exp_ar_len[1] = 8'd15; exp_ar_n = 2;
      xfer(32'h0000_0FC0, 16'd20);

      // Zero-beat request: busy for two cycles, no AR, no user words.
      send_req(32'h0000_6000, 16'd0);
      busy_cnt = 0; ar_cnt = 0; uv_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         busy_cnt += int'(o_busy);
         ar_cnt   += int'(o_axi_arvalid);
         uv_cnt   += int'(o_user_valid);
         step();
      end
      check("zero_busy_cycles", busy_cnt, 2);
      check("zero_no_ar", ar_cnt, 0);
      check("zero_no_user", uv_cnt, 0);
      check("zero_req_ready", o_req_ready, 1);

      // Start address at the top of the address space wraps to 0.
      exp_ar_addr[0] = 32'hFFFF_FFE0; exp_ar_len[0] = 8'd1;
      exp_ar_addr[1] = 32'h0000_0000; exp_ar_len[1] = 8'd1; exp_ar_n = 2;
      xfer(32'hFFFF_FFE0, 16'd4);

      // Error response on beat 2 (counting from 0) makes rd_err sticky when the check is built.
      err_beat = 2;
      exp_ar_addr[0] = 32'h0000_4000; exp_ar_len[0] = 8'd3; exp_ar_n = 1;
      xfer(32'h0000_4000, 16'd4);
      err_beat = -1;
      check("rd_err_set", o_rd_err, EXP_ERR);
      repeat (3) step();
      check("rd_err_sticky", o_rd_err, EXP_ERR);

      // Long request with slow R beats and a half-rate consumer. It is long enough
      // that the buffer fills and the room reservation must hold AR back.
      rd_delay     = 3;
      toggle_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         exp_ar_addr[k] = 32'h0000_2000 + 32'(k * 256);
         exp_ar_len[k]  = 8'd15;
      end
      exp_ar_n = 8;
      xfer(32'h0000_2000, 16'd128);
      check("rd_err_cleared", o_rd_err, 0);
      rd_delay     = 0;
      toggle_ready = 1'b0;

      // Reset in the middle of a burst.
      send_req(32'h0000_3000, 16'd8);
      i_axi_arready = 1'b1;
      n = 0;
      while (!o_axi_arvalid && n < 100) begin step(); n++; end
      check("rst_test_ar", o_axi_arvalid, 1);
      step();
      i_axi_arready = 1'b0;
      n = 0;
      while (!o_axi_rready && n < 100) begin step(); n++; end
      check("rst_test_rready", o_axi_rready, 1);
      i_axi_rvalid = 1'b1;
      i_axi_rdata  = beat_data(32'h0000_3000);
      step();
      i_axi_rdata  = beat_data(32'h0000_3010);
      step();
      i_rst = 1'b1;
      step();
      check("mid_rst_req_ready", o_req_ready, 0);
      check("mid_rst_arvalid", o_axi_arvalid, 0);
      check("mid_rst_araddr", o_axi_araddr, 0);
      check("mid_rst_arlen", o_axi_arlen, 0);
      check("mid_rst_rready", o_axi_rready, 0);
      check("mid_rst_user", {o_user_data, o_user_valid, o_user_last}, 0);
      check("mid_rst_busy", o_busy, 0);
      check("mid_rst_rd_err", o_rd_err, 0);
      i_rst        = 1'b0;
      i_axi_rvalid = 1'b0;

      // A fresh request after the reset must see an empty buffer.
      exp_ar_addr[0] = 32'h0000_5000; exp_ar_len[0] = 8'd3; exp_ar_n = 1;
      xfer(32'h0000_5000, 16'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
